// File: rtl/uart_fifo.sv
// uart_fifo: TX and RX byte FIFOs between the CPU I/O port and an unbuffered UART.
// The TX side drains one byte into the UART whenever it reports ready.
// The RX side unloads every received byte at once. A byte that arrives while
// the RX FIFO is full is dropped and sets the sticky overrun flag.
//
// Handshake semantics, both directions:
//   TX: uart_ready acts as the consumer's ready and ~tx_empty as our valid.
//       uart_wr = valid & ready, and the byte on uart_din is transferred on
//       that edge. The UART drops ready after each accepted byte.
//   RX: uart_full acts as the producer's valid and we are always ready.
//       uart_rd echoes uart_full, so the byte on uart_dout is consumed on
//       every edge where uart_full is high, whether it is stored or dropped.
//   Host: tx_wr is accepted only when ~tx_full. rx_rd is accepted only
//       when ~rx_empty. Strobes that are not accepted have no effect.
module uart_fifo #(
  parameter int TXLOG2 = 4,
  parameter int RXLOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_wr,
  input  logic [7:0]        tx_data,
  output logic              tx_full,
  output logic [TXLOG2:0]   tx_count,
  input  logic              rx_rd,
  output logic [7:0]        rx_data,
  output logic              rx_empty,
  output logic [RXLOG2:0]   rx_count,
  output logic              overrun,
  input  logic              overrun_clr,
  input  logic              uart_ready,
  output logic              uart_wr,
  output logic [7:0]        uart_din,
  input  logic              uart_full,
  output logic              uart_rd,
  input  logic [7:0]        uart_dout
);

  localparam int TX_DEPTH = 1 << TXLOG2;
  localparam int RX_DEPTH = 1 << RXLOG2;
  localparam logic [TXLOG2:0] TX_FULL_CNT = (TXLOG2+1)'(TX_DEPTH);
  localparam logic [RXLOG2:0] RX_FULL_CNT = (RXLOG2+1)'(RX_DEPTH);

  // Storage (not reset)
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];

  // Pointers and occupancy
  logic [TXLOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXLOG2:0]   tx_count_q, tx_count_d;
  logic [RXLOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXLOG2:0]   rx_count_q, rx_count_d;
  logic              overrun_q, overrun_d;

  // Qualified strobes
  logic tx_empty;
  logic rx_full;
  logic tx_push, tx_pop;
  logic rx_push, rx_pop, rx_drop;

  // Flags come from the registered counts, so they reflect the start of the cycle
  always_comb begin
    tx_full  = (tx_count_q == TX_FULL_CNT);
    tx_empty = (tx_count_q == '0);
    rx_full  = (rx_count_q == RX_FULL_CNT);
    rx_empty = (rx_count_q == '0);
    tx_push  = tx_wr & ~tx_full;
    tx_pop   = uart_ready & ~tx_empty;
    rx_push  = uart_full & ~rx_full;
    rx_drop  = uart_full & rx_full;
    rx_pop   = rx_rd & ~rx_empty;
  end

  // Output decode: UART strobes and head bytes, zeroed when the FIFO is empty
  always_comb begin
    uart_wr  = tx_pop;
    uart_rd  = uart_full;
    uart_din = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];
    rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
    tx_count = tx_count_q;
    rx_count = rx_count_q;
    overrun  = overrun_q;
  end

  // Next-state for pointers, counts and the sticky overrun flag
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    overrun_d  = overrun_q;

    if (tx_push) tx_wptr_d = tx_wptr_q + TXLOG2'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + TXLOG2'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (TXLOG2+1)'(1);
      2'b01:   tx_count_d = tx_count_q - (TXLOG2+1)'(1);
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_push) rx_wptr_d = rx_wptr_q + RXLOG2'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + RXLOG2'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (RXLOG2+1)'(1);
      2'b01:   rx_count_d = rx_count_q - (RXLOG2+1)'(1);
      default: rx_count_d = rx_count_q;
    endcase

    // A dropped byte wins over a clear arriving in the same cycle
    if (rx_drop)          overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      overrun_q  <= overrun_d;
    end
  end

  // TX storage write port
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
  end

  // RX storage write port
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_dout;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed test-plan steps followed by a randomized phase.
// A queue-based reference model predicts every output each cycle.
module tb_uart_fifo;

  localparam int TXD = 16;
  localparam int RXD = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       uart_ready = 1'b0;
  logic       uart_wr;
  logic [7:0] uart_din;
  logic       uart_full = 1'b0;
  logic       uart_rd;
  logic [7:0] uart_dout = 8'h00;

  uart_fifo #(.TXLOG2(4), .RXLOG2(4)) dut (
    .clk(clk), .rst(rst),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .uart_ready(uart_ready), .uart_wr(uart_wr), .uart_din(uart_din),
    .uart_full(uart_full), .uart_rd(uart_rd), .uart_dout(uart_dout)
  );

  // Reference model and scoreboard state
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       ovr_m = 1'b0;
  logic [7:0] tx_seen[$];
  int         n_vec = 0;
  int         n_err = 0;

  // UART transmit-side model
  logic uart_auto = 1'b0;
  int   u_timer = 0;
  int   char_min = 3;
  int   char_max = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model for the current inputs
  task automatic check_all();
    int tsz, rsz;
    tsz = tx_exp_q.size();
    rsz = rx_exp_q.size();
    chk("tx_full",  32'(tx_full),  32'(tsz == TXD));
    chk("tx_count", 32'(tx_count), 32'(tsz));
    chk("uart_wr",  32'(uart_wr),  32'(uart_ready && tsz != 0));
    chk("uart_din", 32'(uart_din), 32'((tsz != 0) ? tx_exp_q[0] : 8'h00));
    chk("rx_empty", 32'(rx_empty), 32'(rsz == 0));
    chk("rx_count", 32'(rx_count), 32'(rsz));
    chk("rx_data",  32'(rx_data),  32'((rsz != 0) ? rx_exp_q[0] : 8'h00));
    chk("uart_rd",  32'(uart_rd),  32'(uart_full));
    chk("overrun",  32'(overrun),  32'(ovr_m));
  endtask

  // Apply the rules of one clock edge to the queue model
  task automatic model_update();
    logic tx_full0, rx_full0;
    if (rst) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      ovr_m = 1'b0;
      return;
    end
    tx_full0 = (tx_exp_q.size() == TXD);
    rx_full0 = (rx_exp_q.size() == RXD);
    if (uart_ready && tx_exp_q.size() != 0) void'(tx_exp_q.pop_front());
    if (tx_wr && !tx_full0) tx_exp_q.push_back(tx_data);
    if (rx_rd && rx_exp_q.size() != 0) void'(rx_exp_q.pop_front());
    if (uart_full && !rx_full0) rx_exp_q.push_back(uart_dout);
    if (uart_full && rx_full0) ovr_m = 1'b1;
    else if (overrun_clr)      ovr_m = 1'b0;
  endtask

  // One clock: check, capture UART traffic, edge, model, UART responses
  task automatic cycle();
    logic dut_wr, dut_rd;
    #1;
    check_all();
    dut_wr = uart_wr;
    dut_rd = uart_rd;
    if (dut_wr) tx_seen.push_back(uart_din);
    @(posedge clk);
    model_update();
    #1;
    tx_wr = 1'b0;
    rx_rd = 1'b0;
    overrun_clr = 1'b0;
    rst = 1'b0;
    if (dut_rd) uart_full = 1'b0;
    if (uart_auto) begin
      if (dut_wr) begin
        uart_ready = 1'b0;
        u_timer = $urandom_range(char_max, char_min);
      end else if (!uart_ready) begin
        if (u_timer <= 1) uart_ready = 1'b1;
        else u_timer--;
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_data = b;
    cycle();
  endtask

  task automatic deliver_rx(input logic [7:0] b);
    uart_full = 1'b1;
    uart_dout = b;
    cycle();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_exp_q.delete();
    rx_exp_q.delete();
    ovr_m = 1'b0;
    cycle();
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);

    // Step 1: three bytes through a ready UART
    uart_auto = 1'b1;
    uart_ready = 1'b1;
    tx_seen.delete();
    push_tx(8'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    for (int i = 0; i < 100 && (tx_exp_q.size() != 0 || !uart_ready); i++) cycle();
    chk("s1_nbytes", 32'(tx_seen.size()), 32'd3);
    if (tx_seen.size() == 3) begin
      chk("s1_b0", 32'(tx_seen[0]), 32'h41);
      chk("s1_b1", 32'(tx_seen[1]), 32'h42);
      chk("s1_b2", 32'(tx_seen[2]), 32'h43);
    end
    chk("s1_tx_count", 32'(tx_count), 32'd0);

    // Step 2: fill TX with ready held low, 17th byte discarded
    uart_auto = 1'b0;
    uart_ready = 1'b0;
    for (int i = 0; i < 17; i++) push_tx(8'(i));
    chk("s2_tx_full", 32'(tx_full), 32'd1);
    chk("s2_tx_count", 32'(tx_count), 32'd16);
    tx_seen.delete();
    uart_auto = 1'b1;
    uart_ready = 1'b1;
    for (int i = 0; i < 200 && (tx_exp_q.size() != 0 || !uart_ready); i++) cycle();
    chk("s2_nbytes", 32'(tx_seen.size()), 32'd16);
    for (int i = 0; i < 16 && i < tx_seen.size(); i++) chk("s2_order", 32'(tx_seen[i]), 32'(i));

    // Step 3: single received byte
    deliver_rx(8'h5A);
    chk("s3_uart_full_cleared", 32'(uart_full), 32'd0);
    cycle();
    chk("s3_rx_count", 32'(rx_count), 32'd1);
    chk("s3_rx_data", 32'(rx_data), 32'h5A);
    rx_rd = 1'b1;
    cycle();
    chk("s3_rx_empty", 32'(rx_empty), 32'd1);
    chk("s3_rx_data0", 32'(rx_data), 32'h00);

    // Step 4: 17 received bytes, overrun, clear, drain in order
    for (int i = 0; i < 17; i++) deliver_rx(8'h80 + 8'(i));
    chk("s4_rx_count", 32'(rx_count), 32'd16);
    chk("s4_overrun", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    cycle();
    chk("s4_overrun_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("s4_order", 32'(rx_data), 32'h80 + 32'(i));
      rx_rd = 1'b1;
      cycle();
    end
    chk("s4_rx_empty", 32'(rx_empty), 32'd1);

    // Step 5: RX full, simultaneous receive and pop
    for (int i = 0; i < 16; i++) deliver_rx(8'hA0 + 8'(i));
    uart_full = 1'b1;
    uart_dout = 8'hFF;
    rx_rd = 1'b1;
    cycle();
    chk("s5_rx_count", 32'(rx_count), 32'd15);
    chk("s5_overrun", 32'(overrun), 32'd1);
    chk("s5_head", 32'(rx_data), 32'hA1);
    for (int i = 0; i < 10; i++) begin
      rx_rd = 1'b1;
      cycle();
    end

    // Step 6: reset with bytes queued and a UART write in progress
    for (int i = 0; i < 5; i++) begin
      rx_rd = 1'b1;
      cycle();
    end
    uart_auto = 1'b0;
    uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_tx(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) deliver_rx(8'h20 + 8'(i));
    chk("s6_pre_overrun", 32'(overrun), 32'd1);
    uart_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("s6_pre_uart_wr", 32'(uart_wr), 32'd1);
    cycle();
    chk("s6_tx_count", 32'(tx_count), 32'd0);
    chk("s6_rx_count", 32'(rx_count), 32'd0);
    chk("s6_rx_empty", 32'(rx_empty), 32'd1);
    chk("s6_uart_wr", 32'(uart_wr), 32'd0);
    chk("s6_overrun", 32'(overrun), 32'd0);

    // Randomized traffic against the model
    uart_auto = 1'b1;
    char_min = 1;
    char_max = 6;
    for (int i = 0; i < 1500; i++) begin
      tx_wr = ($urandom_range(0, 2) != 0);
      tx_data = 8'($urandom);
      rx_rd = (i < 750) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      if (!uart_full && $urandom_range(0, 1) == 0) begin
        uart_full = 1'b1;
        uart_dout = 8'($urandom);
      end
      overrun_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
